// File: rtl/fifo_duth_pkg.sv
// Shared sizing helpers for the flexible-depth FIFO and its wrap pointers.
package fifo_duth_pkg;

  // Width of the occupancy counter: must hold every value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a slot index 0..depth-1, never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_duth_wrap_cnt.sv
// Modulo-DEPTH pointer: wraps from DEPTH-1 back to 0 so any depth works,
// not just powers of two. Clear has priority over increment.
module fifo_duth_wrap_cnt #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] value
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Pointer register: async clear on reset, sync clear on flush, else advance with wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == LAST) ? '0 : value + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_duth_flex.sv
// First-word-fall-through FIFO with arbitrary depth, occupancy count,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow indicators.
module fifo_duth_flex
  import fifo_duth_pkg::*;
#(
  parameter int  DW       = 16,
  parameter int  DEPTH    = 4,
  parameter int  AF_LEVEL = DEPTH - 1,
  parameter int  AE_LEVEL = 1,
  localparam int CW       = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] write_data,
  input  logic          push,
  output logic          full,
  output logic          almost_full,
  output logic [DW-1:0] read_data,
  input  logic          pop,
  output logic          empty,
  output logic          almost_empty,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int            PW       = ptr_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_duth_flex: DEPTH must be at least 2");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
    $fatal(1, "fifo_duth_flex: AE_LEVEL must lie in 0..DEPTH-1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_duth_flex: AF_LEVEL must lie in 1..DEPTH");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          pop_ok;
  logic          push_ok;
  logic          wr_en;

  // A pop into an empty FIFO is ignored even if a push arrives the same
  // cycle (no bypass); a push into a full FIFO is fine if a pop frees a slot.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign wr_en   = push_ok & ~flush;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign read_data    = mem[head];

  fifo_duth_wrap_cnt #(.DEPTH(DEPTH), .PW(PW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .inc   (pop_ok),
    .clr   (flush),
    .value (head)
  );

  fifo_duth_wrap_cnt #(.DEPTH(DEPTH), .PW(PW)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .inc   (push_ok),
    .clr   (flush),
    .value (tail)
  );

  // Storage array: written at the tail slot; left unreset since empty hides it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail] <= write_data;
    end
  end

  // Occupancy: flush wins, a simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: set by dropped pushes or ignored pops, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full & ~pop_ok) begin
        overflow <= 1'b1;
      end
      if (pop & empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
